hilo_pipe: RTL and testbench
============================

HILO_PIPE -- requirements
Module: hilo_pipe

Interface
REQ-001 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 Reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 ALUControl  input  6  EX-stage ALU operation code, same encoding the ALU uses.
REQ-004 HI_out  input  32  EX-stage HI result from the ALU.
REQ-005 LO_out  input  32  EX-stage LO result from the ALU.
REQ-006 Stall  input  1  freeze the EX/MEM stage of this block.
REQ-007 Flush  input  1  squash the EX-stage write (branch/jump kill).
REQ-008 HI_in  output  32  forwarded HI value fed back to the ALU.
REQ-009 LO_in  output  32  forwarded LO value fed back to the ALU.
REQ-010 HI_arch  output  32  committed architectural HI register.
REQ-011 LO_arch  output  32  committed architectural LO register.

Function
REQ-012 Decode write enables from ALUControl: 2 (madd), 8 (msub), 19 (mult) and 20 (multu) set weHI and weLO; 16 (mthi) sets weHI only; 18 (mtlo) sets weLO only; all other codes set neither.
REQ-013 Keep three register levels: S1 (EX/MEM: weHI, weLO, hi, lo), S2 (MEM/WB: same fields), ARCH (HI_arch, LO_arch).
REQ-014 When Stall=0 and Flush=0, S1 loads the decoded enables and HI_out/LO_out on each edge.
REQ-015 When Flush=1, S1 write enables clear to 0 on the edge, regardless of Stall; Flush has priority.
REQ-016 When Stall=1 and Flush=0, S1 holds its contents and S2 loads a bubble (both enables 0).
REQ-017 When Stall=0, S2 loads S1 on each edge, whatever the value of Flush.
REQ-018 On each edge, ARCH HI loads S2.hi if S2.weHI=1, else holds; ARCH LO follows the same rule independently with S2.weLO.
REQ-019 HI_in is combinational with priority: S1.hi if S1.weHI, else S2.hi if S2.weHI, else HI_arch. LO_in follows the same rule.
REQ-020 HI_in and LO_in depend only on registered state, never on ALUControl, HI_out or LO_out. This guarantees no combinational loop through the ALU's madd/msub path.
REQ-021 Latency: a write captured at edge N is visible on HI_in/LO_in after edge N and in HI_arch/LO_arch after edge N+2, provided no stall occurs.
REQ-022 Back-to-back writes resolve so the younger write wins forwarding: S1 has priority over S2.
REQ-023 An mthi followed by an mtlo keeps the two halves independent. Neither op clobbers the other register.
REQ-024 A stall lasting k cycles delays commit by k cycles, with no duplicate commit.

Reset
REQ-025 While Reset=0, S1 and S2 enables and data are 0 and HI_arch/LO_arch are 0. As a result HI_in=LO_in=0 immediately, asynchronously.
REQ-026 Reset asserted mid-operation discards all in-flight writes; no partial commit.
REQ-027 The first capture happens on the first rising edge after Reset deasserts.

Structure
REQ-028 The ALUControl codes used (2, 8, 16, 18, 19, 20) are named constants in a shared package also used by the ALU and the controller.
REQ-029 One sub-module, hilo_stage, implements a single pipeline level (enables plus data, with hold/bubble/load control) and is instantiated for S1 and S2.

Verification
REQ-030 The bench shall cover the following directed scenarios:
- mult with HI_out=0x00000001 and LO_out=0xFFFFFFFE -> HI_in/LO_in equal 0x00000001/0xFFFFFFFE one edge later; HI_arch/LO_arch equal the same values after edge N+2.
- mthi 0xAAAA0000, then mtlo 0x0000BBBB the next cycle -> after commit HI_arch=0xAAAA0000 and LO_arch=0x0000BBBB; at each step the forwarded value is the younger one.
- mult 5, then madd writing 7, consecutively -> HI_in shows 7 from S1 while S2 still holds 5; the final ARCH value is 7.
- mthi 0x12345678 with Flush=1 -> no change to HI_in or HI_arch.
- mtlo 0x55 with Stall=1 held for 3 cycles -> S1 holds; LO_arch becomes 0x55 exactly once, 2 edges after Stall drops.
- Reset pulsed low between the capture and the commit of mult 0x9/0x9 -> all outputs 0 asynchronously, and ARCH stays 0 after release.

Source files
------------

// File: rtl/hilo_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_pipe_pkg
// Description : Shared definitions for the HI/LO pipeline. Holds the ALU
//               operation codes that write HI/LO (also used by the ALU and the
//               controller), the pipeline entry type, and the write-enable
//               decoder.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_pipe_pkg;

    localparam int unsigned c_DATA_W     = 32;
    localparam int unsigned c_ALU_CTRL_W = 6;

    // ALUControl codes that touch HI and/or LO
    localparam logic [c_ALU_CTRL_W-1:0] c_ALU_MADD  = 6'd2;
    localparam logic [c_ALU_CTRL_W-1:0] c_ALU_MSUB  = 6'd8;
    localparam logic [c_ALU_CTRL_W-1:0] c_ALU_MTHI  = 6'd16;
    localparam logic [c_ALU_CTRL_W-1:0] c_ALU_MTLO  = 6'd18;
    localparam logic [c_ALU_CTRL_W-1:0] c_ALU_MULT  = 6'd19;
    localparam logic [c_ALU_CTRL_W-1:0] c_ALU_MULTU = 6'd20;

    // One pipeline level: per-half write enables plus the data to write
    typedef struct packed {
        logic                we_hi;
        logic                we_lo;
        logic [c_DATA_W-1:0] hi;
        logic [c_DATA_W-1:0] lo;
    } hilo_entry_t;

    // Returns {we_hi, we_lo} for an ALU operation code
    function automatic logic [1:0] decode_we(input logic [c_ALU_CTRL_W-1:0] ctrl);
        logic [1:0] we;
        case (ctrl)
            c_ALU_MADD,
            c_ALU_MSUB,
            c_ALU_MULT,
            c_ALU_MULTU: we = 2'b11;
            c_ALU_MTHI:  we = 2'b10;
            c_ALU_MTLO:  we = 2'b01;
            default:     we = 2'b00;
        endcase
        return we;
    endfunction

endpackage : hilo_pipe_pkg
`default_nettype wire

// File: rtl/hilo_stage.sv
`default_nettype none
// ============================================================================
// Module      : hilo_stage
// Description : A single HI/LO pipeline level. Each edge it either loads the
//               incoming entry, holds its contents, or loads a bubble (write
//               enables cleared). Bubble has priority over hold.
// Ports       : clk_i    - clock, rising edge
//               rst_ni   - asynchronous active-low reset, clears the entry
//               hold_i   - keep current contents
//               bubble_i - load with both write enables forced to 0
//               entry_i  - entry to load
//               entry_o  - registered entry
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_stage
    import hilo_pipe_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        hold_i,
    input  logic        bubble_i,
    input  hilo_entry_t entry_i,
    output hilo_entry_t entry_o
);

    hilo_entry_t entry_d;
    hilo_entry_t entry_q;

    always_comb begin
        entry_d = entry_i;
        if (bubble_i) begin
            // Data is don't-care once the enables are clear
            entry_d.we_hi = 1'b0;
            entry_d.we_lo = 1'b0;
        end else if (hold_i) begin
            entry_d = entry_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule : hilo_stage
`default_nettype wire

// File: rtl/hilo_pipe.sv
`default_nettype none
// ============================================================================
// Module      : hilo_pipe
// Description : HI/LO register pipeline. EX-stage HI/LO results travel through
//               EX/MEM (S1) and MEM/WB (S2) levels before committing to the
//               architectural HI/LO registers. Forwarded values for the ALU
//               come from registered state only, so the madd/msub feedback
//               path through the ALU cannot form a combinational loop.
// Ports       : Clk        - clock, rising edge
//               Reset      - asynchronous active-low reset
//               ALUControl - EX-stage ALU operation code
//               HI_out     - EX-stage HI result
//               LO_out     - EX-stage LO result
//               Stall      - freeze EX/MEM; MEM/WB receives a bubble
//               Flush      - squash the EX-stage write (wins over Stall)
//               HI_in      - forwarded HI to the ALU
//               LO_in      - forwarded LO to the ALU
//               HI_arch    - committed HI
//               LO_arch    - committed LO
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_pipe
    import hilo_pipe_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [c_ALU_CTRL_W-1:0] ALUControl,
    input  logic [c_DATA_W-1:0]     HI_out,
    input  logic [c_DATA_W-1:0]     LO_out,
    input  logic                    Stall,
    input  logic                    Flush,
    output logic [c_DATA_W-1:0]     HI_in,
    output logic [c_DATA_W-1:0]     LO_in,
    output logic [c_DATA_W-1:0]     HI_arch,
    output logic [c_DATA_W-1:0]     LO_arch
);

    logic [1:0]          w_we;
    hilo_entry_t         w_ex_entry;
    hilo_entry_t         w_s1;
    hilo_entry_t         w_s2;
    logic [c_DATA_W-1:0] hi_arch_d;
    logic [c_DATA_W-1:0] hi_arch_q;
    logic [c_DATA_W-1:0] lo_arch_d;
    logic [c_DATA_W-1:0] lo_arch_q;

    // EX-stage entry built from the operation code and ALU results
    always_comb begin
        w_we             = decode_we(ALUControl);
        w_ex_entry.we_hi = w_we[1];
        w_ex_entry.we_lo = w_we[0];
        w_ex_entry.hi    = HI_out;
        w_ex_entry.lo    = LO_out;
    end

    // S1 (EX/MEM): Flush kills the write even while stalled
    hilo_stage u_s1 (
        .clk_i    (Clk),
        .rst_ni   (Reset),
        .hold_i   (Stall),
        .bubble_i (Flush),
        .entry_i  (w_ex_entry),
        .entry_o  (w_s1)
    );

    // S2 (MEM/WB): a stalled S1 stays put, so S2 must take a bubble to avoid
    // committing the same write twice
    hilo_stage u_s2 (
        .clk_i    (Clk),
        .rst_ni   (Reset),
        .hold_i   (1'b0),
        .bubble_i (Stall),
        .entry_i  (w_s1),
        .entry_o  (w_s2)
    );

    // Architectural registers: halves commit independently
    always_comb begin
        hi_arch_d = hi_arch_q;
        lo_arch_d = lo_arch_q;
        if (w_s2.we_hi) begin
            hi_arch_d = w_s2.hi;
        end
        if (w_s2.we_lo) begin
            lo_arch_d = w_s2.lo;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hi_arch_q <= '0;
            lo_arch_q <= '0;
        end else begin
            hi_arch_q <= hi_arch_d;
            lo_arch_q <= lo_arch_d;
        end
    end

    // Forwarding: the youngest pending write wins (S1 over S2 over ARCH)
    always_comb begin
        if (w_s1.we_hi) begin
            HI_in = w_s1.hi;
        end else if (w_s2.we_hi) begin
            HI_in = w_s2.hi;
        end else begin
            HI_in = hi_arch_q;
        end

        if (w_s1.we_lo) begin
            LO_in = w_s1.lo;
        end else if (w_s2.we_lo) begin
            LO_in = w_s2.lo;
        end else begin
            LO_in = lo_arch_q;
        end
    end

    assign HI_arch = hi_arch_q;
    assign LO_arch = lo_arch_q;

endmodule : hilo_pipe
`default_nettype wire

// File: tb/tb_hilo_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_pipe
// Description : Directed self-checking bench for hilo_pipe. Each step pushes
//               the expected outputs onto a scoreboard queue, drives one clock
//               edge, then pops and compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_pipe;

    localparam logic [5:0] c_NOP   = 6'd0;
    localparam logic [5:0] c_MADD  = 6'd2;
    localparam logic [5:0] c_MTHI  = 6'd16;
    localparam logic [5:0] c_MTLO  = 6'd18;
    localparam logic [5:0] c_MULT  = 6'd19;

    logic        Clk;
    logic        Reset;
    logic [5:0]  ALUControl;
    logic [31:0] HI_out;
    logic [31:0] LO_out;
    logic        Stall;
    logic        Flush;
    logic [31:0] HI_in;
    logic [31:0] LO_in;
    logic [31:0] HI_arch;
    logic [31:0] LO_arch;

    typedef struct {
        string       tag;
        logic [31:0] hi_in;
        logic [31:0] lo_in;
        logic [31:0] hi_arch;
        logic [31:0] lo_arch;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    hilo_pipe dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ALUControl (ALUControl),
        .HI_out     (HI_out),
        .LO_out     (LO_out),
        .Stall      (Stall),
        .Flush      (Flush),
        .HI_in      (HI_in),
        .LO_in      (LO_in),
        .HI_arch    (HI_arch),
        .LO_arch    (LO_arch)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Run-time bound
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish before 20000ns");
        $fatal(1, "timeout");
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] hi_in, input logic [31:0] lo_in,
                            input logic [31:0] hi_arch, input logic [31:0] lo_arch);
        exp_t e;
        e.tag     = tag;
        e.hi_in   = hi_in;
        e.lo_in   = lo_in;
        e.hi_arch = hi_arch;
        e.lo_arch = lo_arch;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.tag, ".HI_in"},   HI_in,   e.hi_in);
            cmp({e.tag, ".LO_in"},   LO_in,   e.lo_in);
            cmp({e.tag, ".HI_arch"}, HI_arch, e.hi_arch);
            cmp({e.tag, ".LO_arch"}, LO_arch, e.lo_arch);
        end
    endtask

    // Drive inputs, record expectation, take one edge, sample #1 after it
    task automatic step(input string tag, input logic [5:0] ctrl, input logic [31:0] hi,
                        input logic [31:0] lo, input logic stall, input logic flush,
                        input logic [31:0] e_hi_in, input logic [31:0] e_lo_in,
                        input logic [31:0] e_hi_arch, input logic [31:0] e_lo_arch);
        ALUControl = ctrl;
        HI_out     = hi;
        LO_out     = lo;
        Stall      = stall;
        Flush      = flush;
        push_exp(tag, e_hi_in, e_lo_in, e_hi_arch, e_lo_arch);
        @(posedge Clk);
        #1;
        check_sb();
    endtask

    initial begin
        Reset      = 1'b0;
        ALUControl = c_MULT;
        HI_out     = 32'hDEAD_BEEF;
        LO_out     = 32'hCAFE_F00D;
        Stall      = 1'b0;
        Flush      = 1'b0;

        // Reset held across an edge with a live mult on the inputs
        #2;
        push_exp("reset_pre", 32'h0, 32'h0, 32'h0, 32'h0);
        check_sb();
        @(posedge Clk);
        #1;
        push_exp("reset_edge", 32'h0, 32'h0, 32'h0, 32'h0);
        check_sb();
        ALUControl = c_NOP;
        #1;
        Reset = 1'b1;

        // mult 1/FFFFFFFE: forwarded after edge N, committed after N+2
        step("mult_n",   c_MULT, 32'h1, 32'hFFFF_FFFE, 0, 0, 32'h1, 32'hFFFF_FFFE, 32'h0, 32'h0);
        step("mult_n1",  c_NOP,  32'h0, 32'h0,         0, 0, 32'h1, 32'hFFFF_FFFE, 32'h0, 32'h0);
        step("mult_n2",  c_NOP,  32'h0, 32'h0,         0, 0, 32'h1, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFE);

        // mthi then mtlo: halves stay independent (junk on the unused half)
        step("mthi",     c_MTHI, 32'hAAAA_0000, 32'h0000_DEAD, 0, 0,
             32'hAAAA_0000, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFE);
        step("mtlo",     c_MTLO, 32'h0000_1111, 32'h0000_BBBB, 0, 0,
             32'hAAAA_0000, 32'h0000_BBBB, 32'h1, 32'hFFFF_FFFE);
        step("mthi_cmt", c_NOP,  32'h0, 32'h0, 0, 0,
             32'hAAAA_0000, 32'h0000_BBBB, 32'hAAAA_0000, 32'hFFFF_FFFE);
        step("mtlo_cmt", c_NOP,  32'h0, 32'h0, 0, 0,
             32'hAAAA_0000, 32'h0000_BBBB, 32'hAAAA_0000, 32'h0000_BBBB);

        // mult 5 then madd 7: S1 (7) wins over S2 (5), final ARCH is 7
        step("mult5",    c_MULT, 32'h5, 32'h5, 0, 0, 32'h5, 32'h5, 32'hAAAA_0000, 32'h0000_BBBB);
        step("madd7",    c_MADD, 32'h7, 32'h7, 0, 0, 32'h7, 32'h7, 32'hAAAA_0000, 32'h0000_BBBB);
        step("mult5_cmt", c_NOP, 32'h0, 32'h0, 0, 0, 32'h7, 32'h7, 32'h5, 32'h5);
        step("madd7_cmt", c_NOP, 32'h0, 32'h0, 0, 0, 32'h7, 32'h7, 32'h7, 32'h7);

        // Flushed mthi never becomes visible
        step("flush",    c_MTHI, 32'h1234_5678, 32'h0, 0, 1, 32'h7, 32'h7, 32'h7, 32'h7);
        step("flush_n1", c_NOP,  32'h0, 32'h0,         0, 0, 32'h7, 32'h7, 32'h7, 32'h7);
        step("flush_n2", c_NOP,  32'h0, 32'h0,         0, 0, 32'h7, 32'h7, 32'h7, 32'h7);

        // Flush together with Stall still kills the write
        step("flush_stall", c_MTHI, 32'h1234_5678, 32'h0, 1, 1, 32'h7, 32'h7, 32'h7, 32'h7);
        step("flush_stall_n1", c_NOP, 32'h0, 32'h0,       0, 0, 32'h7, 32'h7, 32'h7, 32'h7);
        step("flush_stall_n2", c_NOP, 32'h0, 32'h0,       0, 0, 32'h7, 32'h7, 32'h7, 32'h7);

        // mtlo 0x55 then 3 stalled cycles (a mult on the inputs must be ignored)
        step("mtlo55",   c_MTLO, 32'h0, 32'h55, 0, 0, 32'h7, 32'h55, 32'h7, 32'h7);
        step("stall1",   c_MULT, 32'hBAD, 32'hBAD, 1, 0, 32'h7, 32'h55, 32'h7, 32'h7);
        step("stall2",   c_MULT, 32'hBAD, 32'hBAD, 1, 0, 32'h7, 32'h55, 32'h7, 32'h7);
        step("stall3",   c_MULT, 32'hBAD, 32'hBAD, 1, 0, 32'h7, 32'h55, 32'h7, 32'h7);
        step("unstall1", c_NOP,  32'h0, 32'h0, 0, 0, 32'h7, 32'h55, 32'h7, 32'h7);
        step("unstall2", c_NOP,  32'h0, 32'h0, 0, 0, 32'h7, 32'h55, 32'h7, 32'h55);
        step("unstall3", c_NOP,  32'h0, 32'h0, 0, 0, 32'h7, 32'h55, 32'h7, 32'h55);

        // mult 9/9 captured, then Reset pulsed before it commits
        step("mult9",    c_MULT, 32'h9, 32'h9, 0, 0, 32'h9, 32'h9, 32'h7, 32'h55);
        ALUControl = c_NOP;
        HI_out     = 32'h0;
        LO_out     = 32'h0;
        #2;
        Reset = 1'b0;
        #1;
        push_exp("rst_async", 32'h0, 32'h0, 32'h0, 32'h0);
        check_sb();
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        step("rst_rel1", c_NOP, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        step("rst_rel2", c_NOP, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

        // First capture after release behaves normally
        step("post_rst", c_MTHI, 32'h0000_00C3, 32'h0, 0, 0, 32'hC3, 32'h0, 32'h0, 32'h0);

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard: observed %0d leftover entries, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_hilo_pipe
`default_nettype wire
